// File: rtl/puf_resp_serializer.sv
`default_nettype none
// ============================================================================
// Module      : puf_resp_serializer
// Description : Captures the PUF response on a rising edge of puf_done and
//               streams it out as a byte frame over valid/ready:
//               header, response bytes MSB-first, optional XOR checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module puf_resp_serializer #(
    parameter int         DATA_W     = 128,
    parameter logic [7:0] HDR_BYTE   = 8'hA5,
    parameter int         SEND_CKSUM = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] puf_out,
    input  logic              puf_done,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_last,
    output logic              busy,
    output logic              sent_done,
    output logic [7:0]        frame_cnt
);

    localparam int                 c_NB       = DATA_W / 8;
    localparam int                 c_IDX_W    = (c_NB > 1) ? $clog2(c_NB) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NB - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_DATA  = 3'd2,
        S_CKSUM = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_done_q;
    logic [DATA_W-1:0]   r_shadow;
    logic [c_IDX_W-1:0]  r_idx;
    logic [7:0]          r_cksum;
    logic                r_busy;
    logic                r_sent_done;
    logic [7:0]          r_frame_cnt;

    logic                w_trigger;
    logic                w_hs;
    logic [DATA_W-1:0]   w_shifted;
    logic [7:0]          w_data_byte;

    // A capture only starts from a quiescent state; mid-frame edges are dropped.
    assign w_trigger = puf_done & ~r_done_q & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_hs      = tx_valid & tx_ready;

    // Current data byte: move byte idx to the top of the snapshot.
    assign w_shifted   = r_shadow << {r_idx, 3'b000};
    assign w_data_byte = w_shifted[DATA_W-1 -: 8];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and stream outputs; outputs depend only on registered state.
    always_comb begin
        w_state_nxt = r_state;
        tx_data     = 8'h00;
        tx_valid    = 1'b0;
        tx_last     = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_trigger) begin
                    w_state_nxt = S_HDR;
                end
            end
            S_HDR: begin
                tx_valid = 1'b1;
                tx_data  = HDR_BYTE;
                if (tx_ready) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                tx_valid = 1'b1;
                tx_data  = w_data_byte;
                tx_last  = (SEND_CKSUM == 0) && (r_idx == c_LAST_IDX);
                if (tx_ready && (r_idx == c_LAST_IDX)) begin
                    w_state_nxt = (SEND_CKSUM != 0) ? S_CKSUM : S_DONE;
                end
            end
            S_CKSUM: begin
                tx_valid = 1'b1;
                tx_data  = r_cksum;
                tx_last  = 1'b1;
                if (tx_ready) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: edge detect, snapshot, byte index, checksum and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_done_q    <= 1'b0;
            r_shadow    <= '0;
            r_idx       <= '0;
            r_cksum     <= 8'h00;
            r_busy      <= 1'b0;
            r_sent_done <= 1'b0;
            r_frame_cnt <= 8'h00;
        end else begin
            r_done_q <= puf_done;
            if (w_trigger) begin
                r_shadow    <= puf_out;
                r_cksum     <= 8'h00;
                r_idx       <= '0;
                r_busy      <= 1'b1;
                r_sent_done <= 1'b0;
            end
            if (w_hs && (r_state == S_DATA)) begin
                r_cksum <= r_cksum ^ w_data_byte;
                r_idx   <= r_idx + 1'b1;
            end
            if (w_hs && tx_last) begin
                r_busy      <= 1'b0;
                r_sent_done <= 1'b1;
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign busy      = r_busy;
    assign sent_done = r_sent_done;
    assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_puf_resp_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_puf_resp_serializer
// Description : Self-checking bench for puf_resp_serializer; one instance with
//               checksum, one without, sharing clock, reset and stream ready.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_puf_resp_serializer;

    localparam logic [127:0] c_TEXT = 128'h5468697349734E6F74576F726B696E67;
    localparam logic [127:0] c_CNT  = 128'h000102030405060708090A0B0C0D0E0F;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] puf_out;
    logic         done_a, done_b;
    logic         tx_ready;
    logic [7:0]   a_data, b_data, a_cnt, b_cnt;
    logic         a_valid, b_valid, a_last, b_last;
    logic         a_busy, b_busy, a_sent, b_sent;

    bit           sel;
    logic [7:0]   w_data, w_cnt;
    logic         w_valid, w_last, w_busy, w_sent;

    int           n_pass  = 0;
    int           n_total = 0;

    typedef struct {
        logic [127:0] puf;
        logic [7:0]   ck;
        bit           rnd;
        bit           glitch;
    } vec_t;

    vec_t tbl [7];

    always #5 clk = ~clk;

    puf_resp_serializer #(.DATA_W(128), .HDR_BYTE(8'hA5), .SEND_CKSUM(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .puf_out(puf_out), .puf_done(done_a),
        .tx_data(a_data), .tx_valid(a_valid), .tx_ready(tx_ready), .tx_last(a_last),
        .busy(a_busy), .sent_done(a_sent), .frame_cnt(a_cnt)
    );

    puf_resp_serializer #(.DATA_W(128), .HDR_BYTE(8'hA5), .SEND_CKSUM(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .puf_out(puf_out), .puf_done(done_b),
        .tx_data(b_data), .tx_valid(b_valid), .tx_ready(tx_ready), .tx_last(b_last),
        .busy(b_busy), .sent_done(b_sent), .frame_cnt(b_cnt)
    );

    assign w_data  = sel ? b_data  : a_data;
    assign w_valid = sel ? b_valid : a_valid;
    assign w_last  = sel ? b_last  : a_last;
    assign w_busy  = sel ? b_busy  : a_busy;
    assign w_sent  = sel ? b_sent  : a_sent;
    assign w_cnt   = sel ? b_cnt   : a_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic set_done(input logic v);
        if (sel) done_b = v;
        else     done_a = v;
    endtask

    function automatic logic [7:0] exp_byte(input logic [127:0] p, input logic [7:0] ck,
                                            input int k, input int len, input bit cks);
        logic [127:0] t;
        if (k == 0) return 8'hA5;
        if (cks && (k == len - 1)) return ck;
        t = p << (8 * (k - 1));
        return t[127:120];
    endfunction

    // Drop puf_done for one cycle, load the response, raise puf_done (at a negedge).
    task automatic start_frame(input logic [127:0] p);
        set_done(1'b0);
        @(negedge clk);
        puf_out = p;
        set_done(1'b1);
    endtask

    // Receive one frame from the selected DUT; called at the negedge puf_done rose.
    task automatic rx_frame(input logic [127:0] p, input logic [7:0] ck, input bit rnd,
                            input bit glitch, output int first, output int lastc);
        int         k       = 0;
        int         cyc     = 0;
        bit         stalled = 1'b0;
        bit         cks     = !sel;
        int         len     = sel ? 17 : 18;
        logic [7:0] pd      = 8'h00;
        logic       pl      = 1'b0;
        first = -1;
        lastc = -1;
        while (k < len && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (glitch) begin
                if (cyc == 4) puf_out = '1;
                if (cyc == 6) set_done(1'b0);
                if (cyc == 8) set_done(1'b1);
            end
            if (stalled) begin
                check("stall_valid", {31'd0, w_valid}, 32'd1);
                check("stall_data", {24'd0, w_data}, {24'd0, pd});
                check("stall_last", {31'd0, w_last}, {31'd0, pl});
            end
            if (w_valid && first < 0) begin
                first = cyc;
                check("busy_in_frame", {31'd0, w_busy}, 32'd1);
                check("sent_done_clr", {31'd0, w_sent}, 32'd0);
            end
            tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (w_valid && tx_ready) begin
                check("byte", {24'd0, w_data}, {24'd0, exp_byte(p, ck, k, len, cks)});
                check("last", {31'd0, w_last}, {31'd0, (k == len - 1)});
                k++;
                lastc = cyc;
            end
            stalled = w_valid && !tx_ready;
            pd      = w_data;
            pl      = w_last;
        end
        check("frame_len", k, len);
        @(negedge clk);
        check("end_valid", {31'd0, w_valid}, 32'd0);
        check("end_busy", {31'd0, w_busy}, 32'd0);
        check("end_sent_done", {31'd0, w_sent}, 32'd1);
    endtask

    initial begin
        int         first, lastc, acc, vcnt;
        logic [7:0] exp_cnt;

        tbl[0] = '{c_TEXT, 8'h08, 1'b0, 1'b0};
        tbl[1] = '{c_TEXT, 8'h08, 1'b1, 1'b0};
        tbl[2] = '{c_CNT, 8'h00, 1'b0, 1'b1};
        tbl[3] = '{128'h0, 8'h00, 1'b1, 1'b0};
        tbl[4] = '{{128{1'b1}}, 8'h00, 1'b0, 1'b0};
        tbl[5] = '{128'h800000000000000000000000000000FF, 8'h7F, 1'b1, 1'b0};
        tbl[6] = '{128'hDEADBEEF000000000000000000000000, 8'h22, 1'b0, 1'b0};

        sel = 1'b0; rst_n = 1'b0; done_a = 1'b0; done_b = 1'b0;
        tx_ready = 1'b0; puf_out = '0;
        repeat (3) @(negedge clk);
        check("rst_data", {24'd0, a_data}, 32'd0);
        check("rst_valid", {31'd0, a_valid}, 32'd0);
        check("rst_last", {31'd0, a_last}, 32'd0);
        check("rst_busy", {31'd0, a_busy}, 32'd0);
        check("rst_sent_done", {31'd0, a_sent}, 32'd0);
        check("rst_frame_cnt", {24'd0, a_cnt}, 32'd0);
        check("rst_b_valid", {31'd0, b_valid}, 32'd0);
        rst_n = 1'b1;

        // Ready while idle must not produce anything.
        tx_ready = 1'b1;
        vcnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (a_valid) vcnt++;
        end
        check("idle_ready_ignored", vcnt, 0);
        check("idle_frame_cnt", {24'd0, a_cnt}, 32'd0);

        // Table-driven frames on the checksum instance.
        exp_cnt = 8'd0;
        for (int i = 0; i < 7; i++) begin
            start_frame(tbl[i].puf);
            rx_frame(tbl[i].puf, tbl[i].ck, tbl[i].rnd, tbl[i].glitch, first, lastc);
            exp_cnt++;
            check("frame_cnt", {24'd0, a_cnt}, {24'd0, exp_cnt});
            if (!tbl[i].rnd) begin
                check("first_latency", first, 1);
                check("frame_cycles", lastc - first, 17);
            end
            if (tbl[i].glitch) begin
                vcnt = 0;
                repeat (30) begin
                    @(negedge clk);
                    if (a_valid) vcnt++;
                end
                check("glitch_no_refire", vcnt, 0);
                check("glitch_frame_cnt", {24'd0, a_cnt}, {24'd0, exp_cnt});
            end
        end

        // Reset after five accepted bytes with puf_done held high.
        start_frame(c_TEXT);
        tx_ready = 1'b1;
        acc = 0;
        for (int c = 0; c < 50 && acc < 5; c++) begin
            @(negedge clk);
            if (a_valid) acc++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rstmid_valid", {31'd0, a_valid}, 32'd0);
        check("rstmid_last", {31'd0, a_last}, 32'd0);
        check("rstmid_busy", {31'd0, a_busy}, 32'd0);
        check("rstmid_frame_cnt", {24'd0, a_cnt}, 32'd0);
        rst_n = 1'b1;
        rx_frame(c_TEXT, 8'h08, 1'b0, 1'b0, first, lastc);
        check("rstmid_first", first, 1);
        check("rstmid_cnt_after", {24'd0, a_cnt}, 32'd1);

        // Instance without checksum: 17-byte frames, then a second trigger.
        sel = 1'b1;
        puf_out = c_TEXT;
        set_done(1'b1);
        rx_frame(c_TEXT, 8'h00, 1'b0, 1'b0, first, lastc);
        check("nock_first", first, 1);
        check("nock_cnt1", {24'd0, w_cnt}, 32'd1);
        start_frame(c_TEXT);
        rx_frame(c_TEXT, 8'h00, 1'b1, 1'b0, first, lastc);
        check("nock_cnt2", {24'd0, w_cnt}, 32'd2);

        // Counter wrap after 256 frames.
        sel = 1'b0;
        rst_n = 1'b0;
        done_a = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            start_frame(c_TEXT);
            rx_frame(c_TEXT, 8'h08, 1'b0, 1'b0, first, lastc);
            if (i == 254) check("cnt_255", {24'd0, a_cnt}, 32'd255);
        end
        check("cnt_wrap", {24'd0, a_cnt}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
